// File: rtl/sse_cost_unit.sv
// rtl/sse_cost_unit.sv - sum-of-squared-error cost engine (subtract/square/accumulate pipeline)
// Optional saturating accumulator: define COST_SATURATE_EN.
module sse_cost_unit #(
  parameter int NUM_CLASSES = 10,
  parameter int CONF_W      = 4,
  parameter int ACC_W       = 12
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic [NUM_CLASSES-1:0]        expected_label,
  input  logic [NUM_CLASSES*CONF_W-1:0] digit_weights,
  output logic                          busy,
  output logic                          done,
  output logic [ACC_W-1:0]              cost_output,
  output logic                          overflow
);

  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN_SQ,
    DRAIN_ACC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CLASSES-1:0]        label_q;
  logic [NUM_CLASSES*CONF_W-1:0] weights_q;
  logic [IDX_W-1:0]              idx;
  logic [CONF_W-1:0]             sub_q;
  logic                          sub_valid;
  logic [CONF_W-1:0]             sq_q;
  logic                          sq_valid;
  logic [ACC_W-1:0]              acc;

  logic                          accept;
  logic                          label_sel;
  logic [CONF_W-1:0]             conf_sel;
  logic [CONF_W-1:0]             diff_nxt;
  logic [2*CONF_W-1:0]           product;
  logic [CONF_W-1:0]             sq_nxt;

  assign accept = (state == IDLE) && start;

  // The target is either all-ones or zero, so |target - conf| reduces to ~conf or conf.
  assign label_sel = label_q[idx];
  assign conf_sel  = weights_q[idx*CONF_W +: CONF_W];
  assign diff_nxt  = label_sel ? ~conf_sel : conf_sel;

  assign product = {{CONF_W{1'b0}}, sub_q} * {{CONF_W{1'b0}}, sub_q};
  assign sq_nxt  = CONF_W'(product >> CONF_W);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_nxt = DRAIN_SQ;
      end
      DRAIN_SQ: begin
        busy      = 1'b1;
        state_nxt = DRAIN_ACC;
      end
      DRAIN_ACC: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      label_q   <= '0;
      weights_q <= '0;
      idx       <= '0;
      sub_q     <= '0;
      sub_valid <= 1'b0;
      sq_q      <= '0;
      sq_valid  <= 1'b0;
    end else begin
      if (accept) begin
        label_q   <= expected_label;
        weights_q <= digit_weights;
        idx       <= '0;
      end else if (state == RUN) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end

      sub_valid <= (state == RUN);
      if (state == RUN) sub_q <= diff_nxt;

      sq_valid <= sub_valid;
      if (sub_valid) sq_q <= sq_nxt;
    end
  end

`ifdef COST_SATURATE_EN
  logic [ACC_W:0] acc_sum;
  logic           ovf_q;

  assign acc_sum = {1'b0, acc} + {{(ACC_W + 1 - CONF_W){1'b0}}, sq_q};

  // Once clamped, any further non-zero add also overflows, so the accumulator stays all-ones.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (sq_valid) begin
      if (acc_sum[ACC_W]) begin
        acc   <= '1;
        ovf_q <= 1'b1;
      end else begin
        acc <= acc_sum[ACC_W-1:0];
      end
    end
  end

  assign overflow = ovf_q;
`else
  logic [ACC_W-1:0] acc_sum;

  assign acc_sum = acc + {{(ACC_W - CONF_W){1'b0}}, sq_q};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= '0;
    end else if (sq_valid) begin
      acc <= acc_sum;
    end
  end

  assign overflow = 1'b0;
`endif

  assign cost_output = acc;

endmodule

// File: tb/tb_sse_cost_unit.sv
// tb/tb_sse_cost_unit.sv - self-checking bench for sse_cost_unit (default and ACC_W=6 instances)
module tb_sse_cost_unit;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [9:0]  expected_label;
  logic [39:0] digit_weights;
  logic        busy, done, overflow;
  logic [11:0] cost_output;
  logic        busy6, done6, overflow6;
  logic [5:0]  cost6;

  int checks;
  int errors;

  sse_cost_unit dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .expected_label(expected_label), .digit_weights(digit_weights),
    .busy(busy), .done(done), .cost_output(cost_output), .overflow(overflow)
  );

  sse_cost_unit #(.NUM_CLASSES(10), .CONF_W(4), .ACC_W(6)) dut6 (
    .clk(clk), .n_rst(n_rst), .start(start),
    .expected_label(expected_label), .digit_weights(digit_weights),
    .busy(busy6), .done(done6), .cost_output(cost6), .overflow(overflow6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  label;
    logic [39:0] w;
    int          exp_cost;
    int          exp_cost6;
    int          exp_ov6;
  } vec_t;

  vec_t vecs[6];

`ifdef COST_SATURATE_EN
  localparam int FULL6 = 63;
  localparam int OV6   = 1;
`else
  localparam int FULL6 = 62;
  localparam int OV6   = 0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [39:0] all_conf(input int c);
    logic [39:0] w;
    for (int i = 0; i < 10; i++) w[i*4 +: 4] = 4'(c);
    return w;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int lat;
    lat = 0;
    @(negedge clk);
    expected_label = v.label;
    digit_weights  = v.w;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk($sformatf("v%0d busy_after_start", id), int'(busy), 1);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    chk($sformatf("v%0d done_latency", id), lat, 12);
    chk($sformatf("v%0d cost", id), int'(cost_output), v.exp_cost);
    chk($sformatf("v%0d overflow", id), int'(overflow), 0);
    chk($sformatf("v%0d busy_at_done", id), int'(busy), 0);
    chk($sformatf("v%0d done6", id), int'(done6), 1);
    chk($sformatf("v%0d cost6", id), int'(cost6), v.exp_cost6);
    chk($sformatf("v%0d overflow6", id), int'(overflow6), v.exp_ov6);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d done_pulse_end", id), int'(done), 0);
    chk($sformatf("v%0d cost_held", id), int'(cost_output), v.exp_cost);
  endtask

  initial begin
    logic [39:0] ramp;
    vec_t        full;
    int          ndone;
    int          first_done;

    checks = 0;
    errors = 0;

    for (int i = 0; i < 10; i++) ramp[i*4 +: 4] = 4'(i);
    vecs[0] = '{10'b00_0000_1000, 40'h0_0000_F000, 0, 0, 0};
    vecs[1] = '{10'b00_0000_0001, all_conf(0), 14, 14, 0};
    vecs[2] = '{10'b00_0010_0000, all_conf(15), 126, FULL6, OV6};
    vecs[3] = '{10'b00_0000_1000, 40'h0_0000_F000, 0, 0, 0};
    vecs[4] = '{10'b10_0000_0000, all_conf(8), 39, 39, 0};
    vecs[5] = '{10'b00_0000_0011, ramp, 42, 42, 0};
    full    = vecs[2];

    n_rst          = 1'b0;
    start          = 1'b0;
    expected_label = '0;
    digit_weights  = '0;
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset cost", int'(cost_output), 0);
    chk("reset overflow", int'(overflow6), 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Start requests while busy and in DONE must be ignored.
    @(negedge clk);
    expected_label = full.label;
    digit_weights  = full.w;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    ndone      = 0;
    first_done = 0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = c;
      end
      if (c == 4) begin
        expected_label = vecs[0].label;
        digit_weights  = vecs[0].w;
      end
      start = (c == 4 || c == 11 || c == 12);
    end
    start = 1'b0;
    chk("busy_start done_count", ndone, 1);
    chk("busy_start done_latency", first_done, 12);
    chk("busy_start cost", int'(cost_output), 126);
    chk("busy_start idle", int'(busy), 0);

    // Asynchronous reset mid-computation.
    @(negedge clk);
    expected_label = full.label;
    digit_weights  = full.w;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst partial_cost_nonzero", int'(cost_output != 0), 1);
    n_rst = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst cost", int'(cost_output), 0);
    chk("midrst cost6", int'(cost6), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst no_done", int'(done), 0);
    @(negedge clk);
    n_rst = 1'b1;
    run_vec(6, full);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
